// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npc_pkg
//  Description : Shared definitions for the NPC load/store unit: operation
//                kind encodings, RISC-V funct3 size/sign codes and the
//                LSU state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

  // Operation kind presented by the execute stage
  localparam logic [1:0] c_KIND_PASS    = 2'd0;
  localparam logic [1:0] c_KIND_LOAD    = 2'd1;
  localparam logic [1:0] c_KIND_STORE   = 2'd2;
  localparam logic [1:0] c_KIND_ILLEGAL = 2'd3;

  // funct3 size/sign field (stores only use B/H/W)
  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  // LSU control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_unit_if
//  Description : Data-memory request/response port of the load/store unit.
//                master = LSU side, slave = memory side.
//  Ports       : mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wstrb
//                (request); mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
//                (response / write acknowledge).
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_unit_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_wen;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;
  logic            mem_rsp_err;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Purely combinational byte-lane logic for the LSU:
//                legality/alignment check of an incoming op, store lane
//                replication and strobes, and load extraction/extension.
//  Ports       : i_kind/i_funct3/i_addr_lo/i_wdata - incoming op
//                o_is_mem   - legal, aligned load or store
//                o_op_err   - illegal kind, illegal funct3 or misaligned
//                o_st_wdata/o_st_wstrb - lane-placed store data and strobes
//                i_ld_funct3/i_ld_off/i_ld_rdata - latched load info + raw word
//                o_ld_data  - extended load value
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_kind,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_is_mem,
  output logic            o_op_err,
  output logic [XLEN-1:0] o_st_wdata,
  output logic [3:0]      o_st_wstrb,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_off,
  input  logic [XLEN-1:0] i_ld_rdata,
  output logic [XLEN-1:0] o_ld_data
);

  logic            w_f3_ok;
  logic            w_misalign;
  logic [XLEN-1:0] w_ld_shift;

  // Legality and alignment of the incoming op
  always_comb begin
    w_f3_ok    = 1'b0;
    w_misalign = 1'b0;
    case (i_kind)
      c_KIND_LOAD:  w_f3_ok = (i_funct3 == c_F3_B)  || (i_funct3 == c_F3_H)  ||
                              (i_funct3 == c_F3_W)  || (i_funct3 == c_F3_BU) ||
                              (i_funct3 == c_F3_HU);
      c_KIND_STORE: w_f3_ok = (i_funct3 == c_F3_B)  || (i_funct3 == c_F3_H)  ||
                              (i_funct3 == c_F3_W);
      default:      w_f3_ok = 1'b0;
    endcase
    case (i_funct3[1:0])
      2'b01:   w_misalign = i_addr_lo[0];
      2'b10:   w_misalign = (i_addr_lo != 2'b00);
      default: w_misalign = 1'b0;
    endcase
    o_is_mem = w_f3_ok && !w_misalign;
    o_op_err = (i_kind == c_KIND_ILLEGAL) ||
               (((i_kind == c_KIND_LOAD) || (i_kind == c_KIND_STORE)) && !o_is_mem);
  end

  // Store data is replicated across all lanes so the strobes alone select
  // the destination bytes; no barrel shifter needed.
  always_comb begin
    o_st_wdata = i_wdata;
    o_st_wstrb = 4'b0000;
    case (i_funct3[1:0])
      2'b00: begin
        o_st_wdata = {4{i_wdata[7:0]}};
        o_st_wstrb = 4'b0001 << i_addr_lo;
      end
      2'b01: begin
        o_st_wdata = {2{i_wdata[15:0]}};
        o_st_wstrb = 4'b0011 << i_addr_lo;
      end
      default: begin
        o_st_wdata = i_wdata;
        o_st_wstrb = 4'b1111;
      end
    endcase
    if (i_kind != c_KIND_STORE) begin
      o_st_wstrb = 4'b0000;
    end
  end

  // Load extract: bring the addressed byte/half down to bit 0, then extend
  always_comb begin
    w_ld_shift = i_ld_rdata >> {i_ld_off, 3'b000};
    case (i_ld_funct3)
      c_F3_B:  o_ld_data = {{24{w_ld_shift[7]}},  w_ld_shift[7:0]};
      c_F3_H:  o_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      c_F3_W:  o_ld_data = i_ld_rdata;
      c_F3_BU: o_ld_data = {24'd0, w_ld_shift[7:0]};
      c_F3_HU: o_ld_data = {16'd0, w_ld_shift[15:0]};
      default: o_ld_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_unit
//  Description : Load/store unit downstream of execute. Accepts one op at a
//                time, runs a request/response transaction on the data-memory
//                port for legal aligned loads/stores, and returns a
//                write-back value. Pass-through ops return the ALU result.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready, in_addr, in_wdata, in_kind, in_funct3
//                mem  - data-memory port (lsu_unit_if.master)
//                out_valid/out_ready, out_data, out_err
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_unit
  import npc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_addr,
  input  logic [XLEN-1:0]  in_wdata,
  input  logic [1:0]       in_kind,
  input  logic [2:0]       in_funct3,
  lsu_unit_if.master       mem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic             out_err
);

  // Last WAIT count before abort: WAIT lasts exactly TIMEOUT cycles
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;

  logic            w_accept;
  logic            w_is_mem;
  logic            w_op_err;
  logic [XLEN-1:0] w_st_wdata;
  logic [3:0]      w_st_wstrb;
  logic [XLEN-1:0] w_ld_data;
  logic            w_timeout;

  logic [XLEN-1:0] r_addr;
  logic            r_wen;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_wstrb;
  logic [1:0]      r_off;
  logic [2:0]      r_f3;
  logic [7:0]      r_cnt;
  logic [XLEN-1:0] r_data;
  logic            r_err;

  assign w_accept  = (r_state == ST_IDLE) && in_valid;
  assign w_timeout = (r_cnt == c_TO_LAST);

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_kind      (in_kind),
    .i_funct3    (in_funct3),
    .i_addr_lo   (in_addr[1:0]),
    .i_wdata     (in_wdata),
    .o_is_mem    (w_is_mem),
    .o_op_err    (w_op_err),
    .o_st_wdata  (w_st_wdata),
    .o_st_wstrb  (w_st_wstrb),
    .i_ld_funct3 (r_f3),
    .i_ld_off    (r_off),
    .i_ld_rdata  (mem.mem_rsp_rdata),
    .o_ld_data   (w_ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)            w_next = w_is_mem ? ST_REQ : ST_DONE;
      ST_REQ:  if (mem.mem_req_ready)   w_next = ST_WAIT;
      ST_WAIT: if (mem.mem_rsp_valid || w_timeout) w_next = ST_DONE;
      ST_DONE: if (out_ready)           w_next = ST_IDLE;
      default:                          w_next = ST_IDLE;
    endcase
  end

  // Outputs: everything is forced to 0 outside the state that owns it so
  // the bus is quiet whenever no transaction is in flight.
  always_comb begin
    in_ready          = (r_state == ST_IDLE);
    mem.mem_req_valid = (r_state == ST_REQ);
    mem.mem_addr      = (r_state == ST_REQ) ? r_addr  : '0;
    mem.mem_wen       = (r_state == ST_REQ) ? r_wen   : 1'b0;
    mem.mem_wdata     = (r_state == ST_REQ) ? r_wdata : '0;
    mem.mem_wstrb     = (r_state == ST_REQ) ? r_wstrb : 4'b0000;
    out_valid         = (r_state == ST_DONE);
    out_data          = (r_state == ST_DONE) ? r_data : '0;
    out_err           = (r_state == ST_DONE) ? r_err  : 1'b0;
  end

  // Datapath: latched op, wait counter and write-back result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= 4'b0000;
      r_off   <= 2'b00;
      r_f3    <= 3'b000;
      r_cnt   <= 8'd0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= {in_addr[XLEN-1:2], 2'b00};
        r_wen   <= (in_kind == c_KIND_STORE);
        r_wdata <= w_st_wdata;
        r_wstrb <= w_st_wstrb;
        r_off   <= in_addr[1:0];
        r_f3    <= in_funct3;
        if (in_kind == c_KIND_PASS) begin
          r_data <= in_addr;
          r_err  <= 1'b0;
        end else begin
          r_data <= '0;
          r_err  <= w_op_err;
        end
      end
      if ((r_state == ST_REQ) && mem.mem_req_ready) begin
        r_cnt <= 8'd0;
      end
      if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 8'd1;
        if (mem.mem_rsp_valid) begin
          r_err  <= mem.mem_rsp_err;
          r_data <= (mem.mem_rsp_err || r_wen) ? '0 : w_ld_data;
        end else if (w_timeout) begin
          r_err  <= 1'b1;
          r_data <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_unit
//  Description : Self-checking bench for lsu_unit: directed cases followed by
//                randomized ops compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_unit;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [1:0]  in_kind = '0;
  logic [2:0]  in_funct3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_unit_if #(.XLEN(32)) mem_if ();

  lsu_unit #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .in_kind   (in_kind),
    .in_funct3 (in_funct3),
    .mem       (mem_if),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- reference model ----
  function automatic bit m_mem_ok(input logic [1:0] kind, input logic [2:0] f3,
                                  input logic [31:0] addr);
    bit f3ok;
    int sz;
    if (kind == 2'd1)      f3ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else if (kind == 2'd2) f3ok = (f3 <= 2);
    else                   return 1'b0;
    if (!f3ok) return 1'b0;
    sz = 1 << f3[1:0];
    return (addr % sz) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off,
                                         input logic [31:0] rdata);
    longint v;
    int     nb;
    nb = 8 << f3[1:0];
    v  = longint'({32'd0, rdata}) >> (8 * off);
    v  = v & ((longint'(1) << nb) - 1);
    if (!f3[2] && v[nb-1]) v = v - (longint'(1) << nb);
    return v[31:0];
  endfunction

  // ---- one complete operation ----
  task automatic do_op(input logic [1:0] kind, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input bit rerr,
                       input int rdly, input int rspdly, input int hold, input bit tmo);
    bit          ok;
    logic [31:0] exp_data;
    bit          exp_err;
    int          off;
    int          sz;
    int          n;
    logic [3:0]  exp_strb;
    logic [31:0] lane_mask;
    logic [31:0] exp_lanes;

    ok  = m_mem_ok(kind, f3, addr);
    off = int'(addr % 4);
    check("idle_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_kind   = kind;
    in_funct3 = f3;
    in_addr   = addr;
    in_wdata  = wdata;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_addr   = $urandom;
    in_wdata  = $urandom;

    if (!ok) begin
      check("no_req", mem_if.mem_req_valid, 0);
      check("fast_valid", out_valid, 1);
      exp_err  = (kind != 2'd0);
      exp_data = (kind == 2'd0) ? addr : 32'd0;
    end else begin
      sz        = 1 << f3[1:0];
      exp_strb  = (kind == 2'd2) ? 4'(((1 << sz) - 1) << off) : 4'd0;
      lane_mask = '0;
      exp_lanes = '0;
      for (int i = 0; i < 4; i++) begin
        if (exp_strb[i]) begin
          lane_mask[8*i +: 8] = 8'hFF;
          exp_lanes[8*i +: 8] = wdata[8*(i-off) +: 8];
        end
      end
      for (int c = 0; c <= rdly; c++) begin
        check("req_valid", mem_if.mem_req_valid, 1);
        check("req_addr", mem_if.mem_addr, addr & ~32'd3);
        check("req_wen", mem_if.mem_wen, (kind == 2'd2));
        check("req_wstrb", mem_if.mem_wstrb, exp_strb);
        if (kind == 2'd2) check("req_wdata", mem_if.mem_wdata & lane_mask, exp_lanes);
        if (c == rdly) mem_if.mem_req_ready = 1'b1;
        @(posedge clk); #1;
      end
      mem_if.mem_req_ready = 1'b0;
      check("wait_no_req", mem_if.mem_req_valid, 0);
      if (tmo) begin
        n = 0;
        while (!out_valid && n < 400) begin
          @(posedge clk); #1;
          n++;
        end
        check("timeout_cycles", n, TMO);
        exp_err  = 1'b1;
        exp_data = 32'd0;
        // late response while in DONE must not disturb the result
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = rdata;
        @(posedge clk); #1;
        mem_if.mem_rsp_valid = 1'b0;
      end else begin
        for (int c = 0; c < rspdly; c++) begin
          check("wait_no_out", out_valid, 0);
          @(posedge clk); #1;
        end
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = rdata;
        mem_if.mem_rsp_err   = rerr;
        @(posedge clk); #1;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_err   = 1'b0;
        mem_if.mem_rsp_rdata = $urandom;
        exp_err  = rerr;
        exp_data = (kind == 2'd1 && !rerr) ? m_load(f3, off, rdata) : 32'd0;
      end
    end

    for (int c = 0; c <= hold; c++) begin
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp_data);
      check("out_err", out_err, exp_err);
      check("done_in_ready", in_ready, 0);
      if (c == hold) out_ready = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("ret_in_ready", in_ready, 1);
    check("ret_out_valid", out_valid, 0);

    if (tmo) begin
      // late response while in IDLE is ignored
      mem_if.mem_rsp_valid = 1'b1;
      @(posedge clk); #1;
      mem_if.mem_rsp_valid = 1'b0;
      check("late_rsp_idle_valid", out_valid, 0);
      check("late_rsp_idle_ready", in_ready, 1);
      check("late_rsp_idle_req", mem_if.mem_req_valid, 0);
    end
  endtask

  // ---- reset pulsed while waiting for a response ----
  task automatic reset_in_wait();
    in_valid  = 1'b1;
    in_kind   = 2'd1;
    in_funct3 = 3'b010;
    in_addr   = 32'h0000_0100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_if.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_if.mem_req_ready = 1'b0;
    check("rst_pre_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_req_valid", mem_if.mem_req_valid, 0);
    check("rst_req_addr", mem_if.mem_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
  endtask

  initial begin
    logic [1:0]  k;
    logic [2:0]  f;
    int          r;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_rdata = '0;
    mem_if.mem_rsp_err   = 1'b0;

    #2;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_req_valid", mem_if.mem_req_valid, 0);
    check("reset_wstrb", mem_if.mem_wstrb, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    do_op(2'd0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0);
    do_op(2'd1, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 1'b0, 0, 0, 0, 1'b0);
    do_op(2'd1, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 1'b0, 0, 0, 0, 1'b0);
    do_op(2'd2, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 1'b0, 3, 0, 0, 1'b0);
    do_op(2'd1, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0);
    do_op(2'd1, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0);
    do_op(2'd3, 3'b010, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0);
    do_op(2'd2, 3'b101, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0);
    do_op(2'd1, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0, 2, 1'b1);
    do_op(2'd1, 3'b010, 32'h8000_0020, 32'h0, 32'hDEAD_BEEF, 1'b1, 0, 1, 0, 1'b0);
    do_op(2'd0, 3'b000, 32'hCAFE_0001, 32'h0, 32'h0, 1'b0, 0, 0, 3, 1'b0);
    reset_in_wait();

    // randomized ops
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      k = 2'd0;
      else if (r <= 4) k = 2'd1;
      else if (r <= 8) k = 2'd2;
      else             k = 2'd3;
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 4);
        case (r)
          0: f = 3'b000;
          1: f = 3'b001;
          2: f = 3'b010;
          3: f = 3'b100;
          default: f = 3'b101;
        endcase
      end
      do_op(k, f, $urandom, $urandom, $urandom, ($urandom_range(0, 9) == 0),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
